// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi master/slave pair: wire-order constants,
// slave FSM states and the wire-index to data-bit mapping.
package quick_spi_pkg;

    localparam int LITTLE_ENDIAN = 0;
    localparam int BIG_ENDIAN    = 1;
    localparam int LSB_FIRST     = 0;
    localparam int MSB_FIRST     = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        OVERRUN
    } state_t;

    // Wire position k (0 = first bit on the bus) to the bit index in the data word.
    function automatic int wire_to_data_index(input int k, input int width,
                                              input int bytes_order, input int bits_order);
        int nb;
        int b;
        int i;
        int data_byte;
        int data_bit;
        nb        = width / 8;
        b         = k / 8;
        i         = k % 8;
        data_byte = (bytes_order != 0) ? (nb - 1 - b) : b;
        data_bit  = (bits_order != 0) ? (7 - i) : i;
        return data_byte * 8 + data_bit;
    endfunction

endpackage

// File: rtl/quick_spi_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with a third stage that
// turns level changes of the synced signal into single-cycle rise/fall pulses.
module quick_spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    // pipe_q[1] is the synced level, pipe_q[2] its previous value
    logic [2:0] pipe_q;
    logic [2:0] pipe_d;

    always_comb begin
        pipe_d = {pipe_q[1:0], din};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= {3{RESET_VAL}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign rise = pipe_q[1] & ~pipe_q[2];
    assign fall = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/quick_spi_slave.sv
// Oversampling SPI slave: frames are delimited by ss_n, mosi is assembled into
// rx_data and tx_data is shifted out on miso using the shared wire ordering.
module quick_spi_slave
    import quick_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BYTES_ORDER = 1,
    parameter int BITS_ORDER  = 0,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_FIRST =
        IDX_W'(wire_to_data_index(0, DATA_WIDTH, BYTES_ORDER, BITS_ORDER));

    // Index 0 is sclk, index 1 is ss_n; both reset to their idle levels.
    logic [1:0] pin_raw;
    logic [1:0] pin_rise;
    logic [1:0] pin_fall;

    assign pin_raw = {ss_n, sclk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        quick_spi_sync #(
            .RESET_VAL((gi == 0) ? (CPOL != 0) : 1'b1)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (pin_raw[gi]),
            .rise  (pin_rise[gi]),
            .fall  (pin_fall[gi])
        );
    end

    // mosi needs the same latency as sclk but no edge detection
    logic mosi_meta_q, mosi_meta_d;
    logic mosi_sync_q, mosi_sync_d;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise;

    assign lead_edge   = (CPOL != 0) ? pin_fall[0] : pin_rise[0];
    assign trail_edge  = (CPOL != 0) ? pin_rise[0] : pin_fall[0];
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign ss_fall     = pin_fall[1];
    assign ss_rise     = pin_rise[1];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shadow_q, tx_shadow_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  busy_q, busy_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  extra_q, extra_d;
    logic [IDX_W-1:0]      cur_idx;

    // Only meaningful while bit_cnt_q < DATA_WIDTH, i.e. in ACTIVE.
    assign cur_idx = IDX_W'(wire_to_data_index(int'(bit_cnt_q), DATA_WIDTH,
                                               BYTES_ORDER, BITS_ORDER));

    always_comb begin
        mosi_meta_d   = mosi;
        mosi_sync_d   = mosi_meta_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shadow_d   = tx_shadow_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = busy_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        extra_d       = extra_q;

        case (state_q)
            IDLE: begin
                if (enable && ss_fall) begin
                    state_d     = ACTIVE;
                    tx_shadow_d = tx_data;
                    rx_shift_d  = '0;
                    bit_cnt_d   = '0;
                    extra_d     = 1'b0;
                    busy_d      = 1'b1;
                    miso_oe_d   = 1'b1;
                    miso_d      = (CPHA != 0) ? 1'b0 : tx_data[IDX_FIRST];
                end
            end
            default: begin
                if (!enable) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                end else begin
                    if (sample_edge) begin
                        if (state_q == ACTIVE) begin
                            rx_shift_d[cur_idx] = mosi_sync_q;
                            bit_cnt_d           = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_d == CNT_FULL) begin
                                state_d = OVERRUN;
                            end
                        end else begin
                            extra_d = 1'b1;
                        end
                    end
                    if (state_q == OVERRUN) begin
                        miso_d = 1'b0;
                    end else if (shift_edge) begin
                        miso_d = tx_shadow_q[cur_idx];
                    end
                    // A sample on the same cycle is already folded into the _d values.
                    if (ss_rise) begin
                        if (bit_cnt_d == CNT_FULL && !extra_d) begin
                            rx_data_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_error_d = 1'b1;
                        end
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        miso_oe_d = 1'b0;
                        miso_d    = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_meta_q   <= 1'b0;
            mosi_sync_q   <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            tx_shadow_q   <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            extra_q       <= 1'b0;
        end else begin
            mosi_meta_q   <= mosi_meta_d;
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shadow_q   <= tx_shadow_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            extra_q       <= extra_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Bench for quick_spi_slave: two instances (BE/LSB mode 0 and LE/MSB mode 3)
// driven by a bit-level master, with a scoreboard of expected frame results.
module tb_quick_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    bit          sel = 1'b0;
    logic        sclk_w = 1'b0;
    logic        ss_w = 1'b1;
    logic        mosi_w = 1'b0;
    logic [15:0] tx_a = '0;
    logic [15:0] tx_b = '0;

    logic        sclk_a, ss_a, mosi_a, sclk_b, ss_b, mosi_b;
    logic        miso_a, miso_oe_a, rx_valid_a, frame_error_a, busy_a;
    logic        miso_b, miso_oe_b, rx_valid_b, frame_error_b, busy_b;
    logic [15:0] rx_data_a, rx_data_b;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;
    logic [15:0] cap = '0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    always #5 clk = ~clk;

    // The idle instance sees an idle bus.
    assign sclk_a = sel ? 1'b0 : sclk_w;
    assign ss_a   = sel ? 1'b1 : ss_w;
    assign mosi_a = sel ? 1'b0 : mosi_w;
    assign sclk_b = sel ? sclk_w : 1'b1;
    assign ss_b   = sel ? ss_w : 1'b1;
    assign mosi_b = sel ? mosi_w : 1'b0;

    quick_spi_slave #(
        .DATA_WIDTH(16), .BYTES_ORDER(1), .BITS_ORDER(0), .CPOL(0), .CPHA(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sclk(sclk_a), .ss_n(ss_a),
        .mosi(mosi_a), .miso(miso_a), .miso_oe(miso_oe_a), .tx_data(tx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_error(frame_error_a),
        .busy(busy_a)
    );

    quick_spi_slave #(
        .DATA_WIDTH(16), .BYTES_ORDER(0), .BITS_ORDER(1), .CPOL(1), .CPHA(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sclk(sclk_b), .ss_n(ss_b),
        .mosi(mosi_b), .miso(miso_b), .miso_oe(miso_oe_b), .tx_data(tx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_error(frame_error_b),
        .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    function automatic int tb_map(input int k, input int bo, input int bi);
        int by;
        int db;
        int di;
        by = k / 8;
        db = (bo != 0) ? (1 - by) : by;
        di = (bi != 0) ? (7 - (k % 8)) : (k % 8);
        return db * 8 + di;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every result pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rx_valid_a || frame_error_a) begin
            exp_t e;
            chk("a_pulse_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                $display("a pulse: rx_valid=%0d frame_error=%0d rx_data=%h", rx_valid_a, frame_error_a, rx_data_a);
                chk("a_frame_error", 32'(frame_error_a), 32'(e.err));
                chk("a_rx_valid", 32'(rx_valid_a), 32'(!e.err));
                chk("a_rx_data", 32'(rx_data_a), 32'(e.data));
            end
        end
        if (rx_valid_b || frame_error_b) begin
            exp_t e;
            chk("b_pulse_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                $display("b pulse: rx_valid=%0d frame_error=%0d rx_data=%h", rx_valid_b, frame_error_b, rx_data_b);
                chk("b_frame_error", 32'(frame_error_b), 32'(e.err));
                chk("b_rx_valid", 32'(rx_valid_b), 32'(!e.err));
                chk("b_rx_data", 32'(rx_data_b), 32'(e.data));
            end
        end
    end

    // One sclk period for wire bit k; miso is checked where the master samples it.
    task automatic spi_bit(input int k, input logic [15:0] txw, input logic [15:0] mw,
                           input bit check_miso);
        int   bo;
        int   bi;
        logic exp_bit;
        logic mbit;
        logic obs_bit;
        bo      = sel ? 0 : 1;
        bi      = sel ? 1 : 0;
        exp_bit = (k < 16) ? txw[tb_map(k, bo, bi)] : 1'b0;
        mbit    = (k < 16) ? mw[tb_map(k, bo, bi)] : 1'b0;
        if (!sel) begin
            mosi_w  = mbit;
            obs_bit = miso_a;
            sclk_w  = ~sclk_w;
            tick(6);
            sclk_w  = ~sclk_w;
            tick(6);
        end else begin
            sclk_w  = ~sclk_w;
            mosi_w  = mbit;
            tick(6);
            obs_bit = miso_b;
            sclk_w  = ~sclk_w;
            tick(6);
        end
        if (check_miso) begin
            chk($sformatf("miso_bit%0d", k), 32'(obs_bit), 32'(exp_bit));
        end
        if (k < 16) cap[15 - k] = obs_bit;
    endtask

    task automatic full_frame(input int nbits, input logic [15:0] txw, input logic [15:0] mw);
        exp_t e;
        if (sel) tx_b = txw; else tx_a = txw;
        ss_w = 1'b0;
        tick(6);
        chk("busy_in_frame", 32'(sel ? busy_b : busy_a), 32'd1);
        chk("oe_in_frame", 32'(sel ? miso_oe_b : miso_oe_a), 32'd1);
        for (int k = 0; k < nbits; k++) spi_bit(k, txw, mw, 1'b1);
        e.err = (nbits != 16);
        if (sel) begin
            if (!e.err) last_b = mw;
            e.data = last_b;
            q_b.push_back(e);
        end else begin
            if (!e.err) last_a = mw;
            e.data = last_a;
            q_a.push_back(e);
        end
        $display("frame dut=%0d bits=%0d tx=%h mosi=%h expect_err=%0d", sel, nbits, txw, mw, e.err);
        ss_w = 1'b1;
        tick(12);
        chk("busy_after_frame", 32'(sel ? busy_b : busy_a), 32'd0);
        chk("oe_after_frame", 32'(sel ? miso_oe_b : miso_oe_a), 32'd0);
        chk("miso_after_frame", 32'(sel ? miso_b : miso_a), 32'd0);
    endtask

    initial begin
        tick(4);
        chk("rst_miso", 32'({miso_a, miso_b}), 32'd0);
        chk("rst_oe", 32'({miso_oe_a, miso_oe_b}), 32'd0);
        chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        chk("rst_pulses", 32'({rx_valid_a, frame_error_a, rx_valid_b, frame_error_b}), 32'd0);
        chk("rst_rx_data", {rx_data_a, rx_data_b}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Mode 0, big endian, LSB first
        full_frame(16, 16'hCC81, 16'hCC81);
        chk("t1_miso_seq", 32'(cap), 32'(16'b0011_0011_1000_0001));

        // Mode 3, little endian, MSB first
        sclk_w = 1'b1;
        sel    = 1'b1;
        tick(4);
        full_frame(16, 16'hA55A, 16'hA55A);
        chk("t2_miso_seq", 32'(cap), 32'(16'h5AA5));
        full_frame(12, 16'h1357, 16'h1234);
        chk("t3_rx_kept", 32'(rx_data_b), 32'(16'hA55A));
        full_frame(20, 16'h9BDF, 16'hFFFF);
        chk("t4_rx_kept", 32'(rx_data_b), 32'(16'hA55A));

        // Enable dropped mid-frame, then restored with ss_n still low
        sclk_w = 1'b0;
        sel    = 1'b0;
        tick(4);
        tx_a = 16'h1234;
        ss_w = 1'b0;
        tick(6);
        for (int k = 0; k < 5; k++) spi_bit(k, 16'h1234, 16'h0F0F, 1'b1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_oe_off", 32'(miso_oe_a), 32'd0);
        chk("t5_busy_off", 32'(busy_a), 32'd0);
        tick(1);
        enable = 1'b1;
        tick(2);
        for (int k = 5; k < 10; k++) spi_bit(k, 16'h1234, 16'h0F0F, 1'b0);
        chk("t5_no_restart", 32'({busy_a, miso_oe_a}), 32'd0);
        ss_w = 1'b1;
        tick(12);
        chk("t5_idle_after", 32'({busy_a, miso_oe_a}), 32'd0);

        // Reset mid-frame, then back-to-back frames
        tx_a = 16'hBEEF;
        ss_w = 1'b0;
        tick(6);
        for (int k = 0; k < 6; k++) spi_bit(k, 16'hBEEF, 16'h7777, 1'b1);
        rst_n  = 1'b0;
        ss_w   = 1'b1;
        sclk_w = 1'b0;
        tick(3);
        rst_n = 1'b1;
        last_a = '0;
        last_b = '0;
        tick(4);
        chk("t6_rst_idle", 32'({busy_a, miso_oe_a, rx_valid_a, frame_error_a}), 32'd0);
        chk("t6_rst_rx_data", 32'(rx_data_a), 32'd0);
        full_frame(16, 16'h0001, 16'h5A3C);
        full_frame(16, 16'h8000, 16'hC3A5);

        tick(10);
        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/quick_spi_slave.md
Name: quick_spi_slave

Overview:
SPI responder (slave) for the quick_spi master. It runs on the system clock and oversamples the SPI pins: sclk, ss_n and mosi pass through 2-FF synchronizers and edge detectors.
Each frame is a fixed DATA_WIDTH bits. tx_data is shifted out on miso and mosi bits are assembled into rx_data, using the same BYTES_ORDER/BITS_ORDER mapping as the master.
It sits at the far end of the bus, one instance per ss_n line, and is used as an FPGA-side peripheral and as a self-checking counterpart for master benches.

Parameters:
DATA_WIDTH, 16, frame length in bits; multiple of 8, range 8..64
BYTES_ORDER, 1, 0 = little endian (byte 0 first on the wire), 1 = big endian (top byte first)
BITS_ORDER, 0, 0 = LSB first within each byte, 1 = MSB first
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on the leading edge, 1 = sample on the trailing edge

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency
rst_n  in  1  synchronous active-low reset
enable  in  1  block enable; low = ignore the bus, abort any frame, release miso
sclk  in  1  SPI clock from master (asynchronous)
ss_n  in  1  slave select, active low (asynchronous)
mosi  in  1  master data (asynchronous)
miso  out  1  slave data
miso_oe  out  1  miso output enable; drives the external tristate
tx_data  in  DATA_WIDTH  word to send, captured at frame start
rx_data  out  DATA_WIDTH  last complete received word
rx_valid  out  1  1-cycle pulse: rx_data updated
frame_error  out  1  1-cycle pulse: frame ended with bit count != DATA_WIDTH
busy  out  1  frame in progress

Behaviour:
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_valid=0, frame_error=0, busy=0, state=IDLE, bit_cnt=0. Reset mid-frame aborts the frame with no pulse.
- Synchronizers: 2 FF per input, plus a third register for edge detection. All decisions use the synced signals.
- Edge definitions:
  - lead_edge = sclk transition away from CPOL; trail_edge = transition back to CPOL.
  - CPHA=0: sample on lead_edge, shift on trail_edge.
  - CPHA=1: shift on lead_edge, sample on trail_edge.
- Wire index k (0..DATA_WIDTH-1) maps to a data bit:
  - byte b = k/8, bit i = k%8.
  - Data byte = (BYTES_ORDER ? NB-1-b : b), where NB = DATA_WIDTH/8.
  - Data bit within byte = (BITS_ORDER ? 7-i : i).
  - The same mapping is used for tx and rx.
- States: IDLE, ACTIVE, OVERRUN.
- IDLE -> ACTIVE on synced ss_n falling edge while enable=1:
  - capture tx_data into tx_shadow; bit_cnt=0; busy=1; miso_oe=1.
  - CPHA=0: miso = bit for k=0 on the same clk edge.
  - CPHA=1: miso = bit for k=0 at the first shift edge.
- ACTIVE, on each sample edge:
  - store synced mosi at mapped position in rx_shift; bit_cnt++.
  - bit_cnt reaching DATA_WIDTH -> OVERRUN.
- ACTIVE, on each shift edge:
  - CPHA=0: drive bit k=bit_cnt.
  - CPHA=1: drive bit k=bit_cnt, counted before the sample.
  - Past the last bit, drive 0.
- OVERRUN: stays on any further sample edge and sets a sticky extra flag; miso=0.
- Synced ss_n rising edge (ACTIVE or OVERRUN), on the same clk:
  - bit_cnt==DATA_WIDTH and no extra bits: rx_data<=rx_shift, rx_valid=1.
  - Otherwise: frame_error=1 and rx_data is unchanged.
  - Then -> IDLE; busy=0, miso_oe=0, miso=0.
- Latency: rx_valid/frame_error pulse 3 clk after the first clk edge that samples ss_n high at the pin. miso for CPHA=0 is valid 3 clk after ss_n low at the pin; the master must provide at least 4 clk setup.
- enable deasserted mid-frame: next clk -> IDLE, miso_oe=0, no pulse. enable reasserted while ss_n is already low: no start; wait for the next falling edge.
- Sample and ss_n rise on the same clk: the sample is counted first, then frame end is evaluated.
- Back-to-back frames: ss_n high for 1 sclk period minimum; the new tx_data is captured at the next fall.
- rx_valid and frame_error are never both high.

Decomposition:
- Package quick_spi_pkg:
  - LITTLE_ENDIAN=0, BIG_ENDIAN=1, LSB_FIRST=0, MSB_FIRST=1.
  - state typedef (IDLE/ACTIVE/OVERRUN).
  - function wire_to_data_index(k, width, bytes_order, bits_order), shared with the master.
- Sub-module quick_spi_sync: 2-FF synchronizer plus rise/fall pulse outputs, instantiated for sclk and ss_n. mosi uses the sync only.

Test Plan:
- DATA_WIDTH=16, BE, LSB first, CPOL=0/CPHA=0, tx_data=16'hCC81, master sends 16'hCC81:
  - miso sequence 0,0,1,1,0,0,1,1,1,0,0,0,0,0,0,1.
  - rx_valid one pulse; rx_data=16'hCC81.
- LE, MSB first, CPOL=1/CPHA=1, tx_data=16'hA55A, mosi 0101_1010_1010_0101:
  - miso emits 0x5A then 0xA5, MSB first.
  - rx_data=16'hA55A.
- 12 sclk cycles then ss_n high -> frame_error pulse, rx_valid=0, rx_data keeps its previous value 16'hA55A.
- 20 sclk cycles -> bits 17..20 ignored, miso=0 after bit 16, frame_error pulse, rx_data unchanged.
- enable=0 after 5 bits -> miso_oe=0 next clk, no pulse. enable=1 with ss_n still low -> no frame until ss_n toggles.
- rst_n low mid-frame, then two back-to-back frames (1 sclk gap) with tx_data 16'h0001 then 16'h8000 -> both frames rx_valid, correct miso per frame, busy low between frames.
